// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_unit
//  Description : Coprocessor-0 exception sink for the 5-stage MIPS pipeline.
//                Decides exception/interrupt entry from the M-stage exception
//                code and the hardware interrupt lines, holds SR/Cause/EPC,
//                and serves mfc0/mtc0/eret.
//                Optional Count/Compare timer enabled by macro CP0_TIMER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_unit #(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4D49,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic [4:0]  ExcCode_M,
  input  logic        BD_M,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_din,
  input  logic        cp0_we,
  input  logic        eret_M,
  output logic        IntReq,
  output logic [31:0] exc_pc,
  output logic [31:0] EPC_out,
  output logic [31:0] cp0_dout
);

  localparam logic [4:0] c_REG_COUNT   = 5'd9;
  localparam logic [4:0] c_REG_COMPARE = 5'd11;
  localparam logic [4:0] c_REG_SR      = 5'd12;
  localparam logic [4:0] c_REG_CAUSE   = 5'd13;
  localparam logic [4:0] c_REG_EPC     = 5'd14;
  localparam logic [4:0] c_REG_PRID    = 5'd15;

  // Architectural state (only the implemented fields are stored)
  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic [5:0]  w_hwint_eff;
  logic        w_int_pend;
  logic        w_exc_pend;
  logic        w_int_req;
  logic        w_mtc0_ok;
  logic [31:0] w_epc_next;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_pend;

  // The timer shares the IP7 line with external interrupt 5
  assign w_hwint_eff = HWInt | {r_timer_pend, 5'b0_0000};
`else
  assign w_hwint_eff = HWInt;
`endif

  // Entry conditions; EXL masks both sources so nesting is impossible
  assign w_int_pend = (|(w_hwint_eff & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_pend = (ExcCode_M != 5'd0) & ~r_sr_exl;
  assign w_int_req  = w_int_pend | w_exc_pend;

  // An mtc0 only lands when neither exception entry nor eret claims the cycle
  assign w_mtc0_ok  = cp0_we & ~w_int_req & ~eret_M;

  // Delay-slot instructions restart at the branch; subtraction wraps freely
  assign w_epc_next = BD_M ? (PC_M - 32'd4) : PC_M;

  assign w_sr    = {16'h0000, r_sr_im, 8'h00, r_sr_exl, r_sr_ie};
  assign w_cause = {r_cause_bd, 15'h0000, r_cause_ip, 3'b000, r_cause_exc, 2'b00};

  assign IntReq  = w_int_req;
  assign exc_pc  = HANDLER_PC;
  assign EPC_out = r_epc;

  // SR/Cause/EPC update: reset, then exception entry, eret, mtc0 in priority
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'd0;
    end else begin
      r_cause_ip <= w_hwint_eff;
      if (w_int_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_int_pend ? 5'd0 : ExcCode_M;
        r_cause_bd  <= BD_M;
        r_epc       <= {w_epc_next[31:2], 2'b00};
      end else if (eret_M) begin
        r_sr_exl <= 1'b0;
      end else if (cp0_we) begin
        case (cp0_addr)
          c_REG_SR: begin
            r_sr_im  <= cp0_din[15:10];
            r_sr_exl <= cp0_din[1];
            r_sr_ie  <= cp0_din[0];
          end
          c_REG_EPC: begin
            r_epc <= {cp0_din[31:2], 2'b00};
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  // Free-running Count, writable Compare, and the sticky match flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count      <= 32'd0;
      r_compare    <= 32'd0;
      r_timer_pend <= 1'b0;
    end else begin
      if (w_mtc0_ok && (cp0_addr == c_REG_COUNT)) begin
        r_count <= cp0_din;
      end else begin
        r_count <= r_count + 32'd1;
      end

      if (w_mtc0_ok && (cp0_addr == c_REG_COMPARE)) begin
        r_compare    <= cp0_din;
        r_timer_pend <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_timer_pend <= 1'b1;
      end
    end
  end
`endif

  // mfc0 read mux; returns pre-edge register contents
  always_comb begin
    cp0_dout = 32'd0;
    case (cp0_addr)
`ifdef CP0_TIMER_EN
      c_REG_COUNT:   cp0_dout = r_count;
      c_REG_COMPARE: cp0_dout = r_compare;
`endif
      c_REG_SR:      cp0_dout = w_sr;
      c_REG_CAUSE:   cp0_dout = w_cause;
      c_REG_EPC:     cp0_dout = r_epc;
      c_REG_PRID:    cp0_dout = PRID_VAL;
      default:       cp0_dout = 32'd0;
    endcase
  end

  // Keep the gated-write term referenced when the timer is compiled out
  logic w_unused;
  assign w_unused = w_mtc0_ok;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_exc_unit
//  Description : Self-checking bench for cp0_exc_unit: directed vector table,
//                hand sequences for reset/timer corners, and randomized
//                stimulus against a mask-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic [31:0] PC_M;
  logic [4:0]  ExcCode_M;
  logic        BD_M;
  logic [5:0]  HWInt;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din;
  logic        cp0_we;
  logic        eret_M;
  logic        IntReq;
  logic [31:0] exc_pc;
  logic [31:0] EPC_out;
  logic [31:0] cp0_dout;

  int n_checks = 0;
  int n_pass   = 0;

  cp0_exc_unit dut (
    .clk      (clk),
    .reset    (reset),
    .PC_M     (PC_M),
    .ExcCode_M(ExcCode_M),
    .BD_M     (BD_M),
    .HWInt    (HWInt),
    .cp0_addr (cp0_addr),
    .cp0_din  (cp0_din),
    .cp0_we   (cp0_we),
    .eret_M   (eret_M),
    .IntReq   (IntReq),
    .exc_pc   (exc_pc),
    .EPC_out  (EPC_out),
    .cp0_dout (cp0_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] pc;
    logic [5:0]  hw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        eret;
    logic        irq;
    logic [4:0]  raddr;
    logic [31:0] rval;
  } vec_t;

  vec_t vt[25];

  // Reference model state, kept as whole 32-bit register images
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    ExcCode_M = 5'd0; BD_M = 1'b0; PC_M = 32'd0; HWInt = 6'd0;
    cp0_we = 1'b0; cp0_addr = 5'd0; cp0_din = 32'd0; eret_M = 1'b0;
  endtask

  // One mtc0/eret cycle with no exception inputs
  task automatic cyc(input logic we, input logic [4:0] a, input logic [31:0] d, input logic er);
    @(negedge clk);
    idle();
    cp0_we = we; cp0_addr = a; cp0_din = d; eret_M = er;
    @(posedge clk);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4D49;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq(input logic [5:0] hw, input logic [4:0] exc);
    logic exl;
    exl = m_sr[1];
    return ((((m_sr >> 10) & 32'h3F & {26'd0, hw}) != 0) && m_sr[0] && !exl) ||
           ((exc != 0) && !exl);
  endfunction

  // Apply the architectural rules at a clock edge
  task automatic m_edge(input logic [4:0] exc, input logic bd, input logic [31:0] pc,
                        input logic [5:0] hw, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic er);
    logic take, intr;
    intr = (((m_sr >> 10) & 32'h3F & {26'd0, hw}) != 0) && m_sr[0] && !m_sr[1];
    take = m_irq(hw, exc);
    m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
    if (take) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (m_cause & 32'h0000_FC00) | ({31'd0, bd} << 31) |
                ((intr ? 32'd0 : {27'd0, exc}) << 2);
      m_epc   = (bd ? pc - 32'd4 : pc) & ~32'h3;
    end else if (er) begin
      m_sr = m_sr & ~32'h2;
    end else if (we) begin
      if (a == 5'd12) m_sr = d & 32'h0000_FC03;
      else if (a == 5'd14) m_epc = d & ~32'h3;
    end
  endtask

  initial begin
    //               exc   bd  pc            hw     we  addr  din            eret irq raddr rval
    vt[0]  = '{5'd12, 1'b0, 32'h3010, 6'd0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd13, 32'h0000_0030};
    vt[1]  = '{5'd12, 1'b0, 32'h3010, 6'd0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd12, 32'h0000_0002};
    vt[2]  = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd14, 32'h0000_3010};
    vt[3]  = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd12, 32'h0000_0000};
    vt[4]  = '{5'd4,  1'b1, 32'h3008, 6'd0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd14, 32'h0000_3004};
    vt[5]  = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd13, 32'h8000_0010};
    vt[6]  = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd12, 32'h0000_0000};
    vt[7]  = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 5'd12, 32'h0000_0401};
    vt[8]  = '{5'd10, 1'b0, 32'h4000, 6'd1, 1'b1, 5'd12, 32'h0,         1'b0, 1'b1, 5'd13, 32'h0000_0400};
    vt[9]  = '{5'd0,  1'b0, 32'h0,    6'd1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd12, 32'h0000_0403};
    vt[10] = '{5'd0,  1'b0, 32'h0,    6'd1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd12, 32'h0000_0401};
    vt[11] = '{5'd0,  1'b0, 32'h5000, 6'd1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd14, 32'h0000_5000};
    vt[12] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd13, 32'h0000_0000};
    vt[13] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd14, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd14, 32'hFFFF_FFFC};
    vt[14] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd13, 32'h0000_0000};
    vt[15] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd15, 32'h0,         1'b0, 1'b0, 5'd15, 32'h0000_4D49};
    vt[16] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd12, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd12, 32'h0000_FC03};
    vt[17] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd20, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd20, 32'h0000_0000};
    vt[18] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd12, 32'h0000_FC01};
    vt[19] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd12, 32'h0,         1'b0, 1'b0, 5'd12, 32'h0000_0000};
    vt[20] = '{5'd8,  1'b1, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd14, 32'hFFFF_FFFC};
    vt[21] = '{5'd8,  1'b0, 32'h0,    6'd0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 5'd12, 32'h0000_0000};
    vt[22] = '{5'd5,  1'b0, 32'h100,  6'd0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 5'd12, 32'h0000_0002};
    vt[23] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd12, 32'h0,         1'b0, 1'b0, 5'd12, 32'h0000_0000};
    vt[24] = '{5'd0,  1'b0, 32'h0,    6'd0, 1'b1, 5'd14, 32'h1234,      1'b1, 1'b0, 5'd14, 32'h0000_0100};

    // Reset check
    idle();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_irq", {31'd0, IntReq}, 32'd0);
    cp0_addr = 5'd12; #1; chk("reset_sr", cp0_dout, 32'd0);
    cp0_addr = 5'd13; #1; chk("reset_cause", cp0_dout, 32'd0);
    cp0_addr = 5'd14; #1; chk("reset_epc", cp0_dout, 32'd0);
    chk("exc_pc", exc_pc, 32'h0000_4180);

    // Directed vector table
    for (int i = 0; i < 25; i++) begin
      ExcCode_M = vt[i].exc; BD_M = vt[i].bd; PC_M = vt[i].pc; HWInt = vt[i].hw;
      cp0_we = vt[i].we; cp0_addr = vt[i].addr; cp0_din = vt[i].din; eret_M = vt[i].eret;
      #1;
      chk($sformatf("vec%0d_irq", i), {31'd0, IntReq}, {31'd0, vt[i].irq});
      @(posedge clk);
      @(negedge clk);
      ExcCode_M = 5'd0; cp0_we = 1'b0; eret_M = 1'b0; cp0_addr = vt[i].raddr;
      #1;
      chk($sformatf("vec%0d_rd", i), cp0_dout, vt[i].rval);
    end

    // Reset arriving while an exception is being taken
    @(negedge clk);
    idle();
    ExcCode_M = 5'd3; PC_M = 32'h700;
    @(posedge clk);
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cp0_addr = 5'd12; #1; chk("midrst_sr", cp0_dout, 32'd0);
    cp0_addr = 5'd13; #1; chk("midrst_cause", cp0_dout, 32'd0);
    chk("midrst_epc", EPC_out, 32'd0);

`ifdef CP0_TIMER_EN
    begin
      logic seen;
      seen = 1'b0;
      cyc(1'b1, 5'd11, 32'd5, 1'b0);
      cyc(1'b1, 5'd9, 32'd0, 1'b0);
      cyc(1'b1, 5'd12, 32'h0000_8001, 1'b0);
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        idle();
        #1;
        if (IntReq) seen = 1'b1;
        else @(posedge clk);
      end
      chk("timer_irq_taken", {31'd0, seen}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cp0_addr = 5'd13; #1;
      chk("timer_ip7", {31'd0, cp0_dout[15]}, 32'd1);
      cyc(1'b1, 5'd11, 32'd0, 1'b0);
      cyc(1'b0, 5'd0, 32'd0, 1'b1);
      @(negedge clk);
      idle();
      #1;
      chk("timer_cleared", {31'd0, IntReq}, 32'd0);
    end
`else
    cyc(1'b1, 5'd9, 32'h0000_ABCD, 1'b0);
    cyc(1'b1, 5'd11, 32'h0000_1234, 1'b0);
    @(negedge clk);
    idle();
    cp0_addr = 5'd9;  #1; chk("no_count", cp0_dout, 32'd0);
    cp0_addr = 5'd11; #1; chk("no_compare", cp0_dout, 32'd0);
`endif

    // Randomized stimulus against the reference model
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a;
      ExcCode_M = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      BD_M      = 1'($urandom);
      PC_M      = $urandom;
      HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      cp0_we    = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       a = 5'd12;
        1:       a = 5'd13;
        2:       a = 5'd14;
        3:       a = 5'd15;
        default: a = 5'($urandom);
      endcase
      if (a == 5'd9 || a == 5'd11) a = 5'd12;
      cp0_addr = a;
      cp0_din  = $urandom;
      eret_M   = ($urandom_range(0, 5) == 0);
      #1;
      chk($sformatf("rnd%0d_irq", n), {31'd0, IntReq}, {31'd0, m_irq(HWInt, ExcCode_M)});
      chk($sformatf("rnd%0d_rd", n), cp0_dout, m_read(cp0_addr));
      chk($sformatf("rnd%0d_epc", n), EPC_out, m_epc);
      @(posedge clk);
      m_edge(ExcCode_M, BD_M, PC_M, HWInt, cp0_we, cp0_addr, cp0_din, eret_M);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
